// File: rtl/pid_pwm_driver_pkg.sv
// ============================================================================
// Module  : pid_pkg (package)
// Purpose : Shared types and helpers for the PID controller and its PWM
//           driver stage: control-effort width, default PWM period, driver
//           state encoding and the saturating |u| >> shift scaling helper.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package pid_pkg;

  localparam int U_W        = 16;    // control effort width (PID u_out)
  localparam int PWM_PERIOD = 1000;  // default PWM period in clk cycles

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DEAD = 2'd2
  } pwm_state_e;

  // |u| >> shift, clamped to limit. Magnitude is computed one bit wider
  // than u so that the most negative value (-32768) maps to +32768.
  function automatic logic [U_W:0] sat_mag_shift(
    input logic [U_W-1:0] u,
    input int unsigned    shift,
    input logic [U_W:0]   limit
  );
    logic [U_W:0] mag;
    logic [U_W:0] scaled;
    mag    = u[U_W-1] ? -{1'b1, u} : {1'b0, u};
    scaled = mag >> shift;
    return (scaled > limit) ? limit : scaled;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pid_pwm_driver_if.sv
// ============================================================================
// Module  : pid_pwm_driver_if (interface)
// Purpose : Bundles the control input and PWM/direction outputs of the
//           PID PWM driver.
// Signals : u_in        - signed control effort from PID u_out
//           en          - synchronous enable, 0 forces idle
//           pwm         - registered PWM output
//           dir         - registered direction (0 fwd, 1 rev)
//           duty        - duty currently applied
//           period_tick - pulse on the last cycle of each period
// Modports: master (drives u_in/en), slave (the driver)
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface pid_pwm_driver_if
  import pid_pkg::*;
#(
  parameter int CNT_W = 10
);
  logic [U_W-1:0]   u_in;
  logic             en;
  logic             pwm;
  logic             dir;
  logic [CNT_W-1:0] duty;
  logic             period_tick;

  modport master (output u_in, en, input pwm, dir, duty, period_tick);
  modport slave  (input u_in, en, output pwm, dir, duty, period_tick);
endinterface

`default_nettype wire

// File: rtl/pid_pwm_driver_period_counter.sv
// ============================================================================
// Module  : pwm_period_counter
// Purpose : PWM period counter. Counts 0..PERIOD-1 and wraps while run_i is
//           high; held at 0 otherwise. Exposes the next count value so the
//           PWM compare can be registered in step with the counter.
// Ports   : clk        - clock
//           reset      - asynchronous active-high reset
//           run_i      - count enable (0 clears the counter)
//           cnt_next_o - value the counter takes on the next edge
//           tick_o     - registered, high while cnt == PERIOD-1
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module pwm_period_counter #(
  parameter int PERIOD = 1000,
  parameter int CNT_W  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_i,
  output logic [CNT_W-1:0] cnt_next_o,
  output logic             tick_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             tick_q;

  always_comb begin
    cnt_d = '0;
    if (run_i) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  // Tick is registered from the next count so it is aligned with cnt_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_d == CNT_LAST);
    end
  end

  assign cnt_next_o = cnt_d;
  assign tick_o     = tick_q;

endmodule

`default_nettype wire

// File: rtl/pid_pwm_driver.sv
// ============================================================================
// Module  : pid_pwm_driver
// Purpose : Converts the signed PID control effort into a PWM duty plus a
//           direction line. Duty and direction are sampled once per period
//           (on period_tick); a direction reversal inserts DEAD_PERIODS full
//           periods with pwm low before the new direction is driven.
// Ports   : clk   - clock
//           reset - asynchronous active-high reset
//           bus   - pid_pwm_driver_if.slave (u_in, en, pwm, dir, duty,
//                   period_tick)
// Options : PWM_SOFTSTART_EN - when defined, each load slews duty toward the
//           new target by at most SLEW_STEP counts per period.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module pid_pwm_driver
  import pid_pkg::*;
#(
  parameter int PERIOD       = PWM_PERIOD,
  parameter int CNT_W        = 10,
  parameter int U_SHIFT      = 5,
  parameter int DEAD_PERIODS = 1,
  parameter int SLEW_STEP    = 50
) (
  input  logic            clk,
  input  logic            reset,
  pid_pwm_driver_if.slave bus
);

  localparam int             DEAD_W    = (DEAD_PERIODS > 1) ? $clog2(DEAD_PERIODS) : 1;
  localparam logic [U_W:0]   SAT_LIMIT = (U_W + 1)'(PERIOD);
  localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_PERIODS - 1);

  pwm_state_e        state_q, state_d;
  logic [CNT_W-1:0]  duty_q, duty_d;
  logic              dir_q, dir_d;
  logic [DEAD_W-1:0] dead_q, dead_d;
  logic              pwm_q, pwm_d;

  logic              w_run;
  logic              w_tick;
  logic [CNT_W-1:0]  w_cnt_next;
  logic [U_W:0]      w_sat;
  logic [CNT_W-1:0]  w_duty_new;
  logic [CNT_W-1:0]  w_load;
  logic              w_zero;
  logic              w_sign;
  logic              w_dir_new;

  // Counter only runs once the FSM has left IDLE and enable is still high,
  // so the first RUN cycle sits at cnt=0.
  assign w_run = (state_q != ST_IDLE) && bus.en;

  pwm_period_counter #(
    .PERIOD (PERIOD),
    .CNT_W  (CNT_W)
  ) u_counter (
    .clk        (clk),
    .reset      (reset),
    .run_i      (w_run),
    .cnt_next_o (w_cnt_next),
    .tick_o     (w_tick)
  );

  assign w_sat      = sat_mag_shift(bus.u_in, U_SHIFT, SAT_LIMIT);
  assign w_duty_new = CNT_W'(w_sat);   // w_sat <= PERIOD, fits in CNT_W
  assign w_zero     = (bus.u_in == '0);
  assign w_sign     = bus.u_in[U_W-1];
  assign w_dir_new  = w_zero ? dir_q : w_sign;

`ifdef PWM_SOFTSTART_EN
  localparam logic [CNT_W-1:0] SLEW = CNT_W'(SLEW_STEP);
  logic [CNT_W-1:0] w_up;
  logic [CNT_W-1:0] w_down;

  // Duty is 0 throughout DEAD, so a load leaving DEAD ramps up from 0.
  always_comb begin
    w_up   = w_duty_new - duty_q;
    w_down = duty_q - w_duty_new;
    if (w_duty_new >= duty_q) begin
      w_load = (w_up > SLEW) ? duty_q + SLEW : w_duty_new;
    end else begin
      w_load = (w_down > SLEW) ? duty_q - SLEW : w_duty_new;
    end
  end
`else
  logic w_unused_slew;
  assign w_unused_slew = ^CNT_W'(SLEW_STEP);
  assign w_load        = w_duty_new;
`endif

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    dir_d   = dir_q;
    dead_d  = dead_q;
    if (!bus.en) begin
      state_d = ST_IDLE;
      duty_d  = '0;
      dead_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_RUN;
          duty_d  = '0;
        end
        ST_RUN: begin
          if (w_tick) begin
            if (!w_zero && (w_sign != dir_q)) begin
              state_d = ST_DEAD;
              dead_d  = DEAD_LOAD;
              duty_d  = '0;
            end else begin
              duty_d = w_load;
            end
          end
        end
        ST_DEAD: begin
          if (w_tick) begin
            if (dead_q != '0) begin
              dead_d = dead_q - 1'b1;
            end else begin
              // Fresh sample decides direction; a flip back during the
              // gap does not extend it.
              state_d = ST_RUN;
              dir_d   = w_dir_new;
              duty_d  = w_load;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          duty_d  = '0;
        end
      endcase
    end
  end

  // Compare against next count/duty so pwm changes on the same edge as the
  // counter: D high cycles starting at cnt=0, and no glitch at duty=PERIOD.
  assign pwm_d = (state_d == ST_RUN) && (w_cnt_next < duty_d);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      duty_q  <= '0;
      dir_q   <= 1'b0;
      dead_q  <= '0;
      pwm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      dir_q   <= dir_d;
      dead_q  <= dead_d;
      pwm_q   <= pwm_d;
    end
  end

  assign bus.pwm         = pwm_q;
  assign bus.dir         = dir_q;
  assign bus.duty        = duty_q;
  assign bus.period_tick = w_tick;

endmodule

`default_nettype wire

// File: tb/tb_pid_pwm_driver.sv
// ============================================================================
// Module  : tb_pid_pwm_driver
// Purpose : Self-checking bench for pid_pwm_driver. A period/phase level
//           reference model predicts pwm, dir, duty and period_tick every
//           cycle; scenario tasks add explicit checks on high-cycle counts.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pid_pwm_driver;

  localparam int PERIOD       = 1000;
  localparam int CNT_W        = 10;
  localparam int U_SHIFT      = 5;
  localparam int DEAD_PERIODS = 1;
  localparam int SLEW_STEP    = 50;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pid_pwm_driver_if #(.CNT_W(CNT_W)) bus ();

  pid_pwm_driver #(
    .PERIOD       (PERIOD),
    .CNT_W        (CNT_W),
    .U_SHIFT      (U_SHIFT),
    .DEAD_PERIODS (DEAD_PERIODS),
    .SLEW_STEP    (SLEW_STEP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: is a period running, where in the period we are,
  // the duty being applied and whether this period is a dead gap.
  bit m_active;
  bit m_dead;
  int m_dead_left;
  int m_phase;
  int m_duty;
  bit m_dir;
  bit e_pwm;
  bit e_tick;

  function automatic int target(input logic [15:0] u);
    int v;
    v = int'($signed(u));
    if (v < 0) v = -v;
    v = v >> U_SHIFT;
    return (v > PERIOD) ? PERIOD : v;
  endfunction

  function automatic int ramp(input int cur, input int tgt);
`ifdef PWM_SOFTSTART_EN
    if (tgt > cur + SLEW_STEP) return cur + SLEW_STEP;
    if (tgt < cur - SLEW_STEP) return cur - SLEW_STEP;
`endif
    return (cur == tgt) ? cur : tgt;
  endfunction

  task automatic model_reset();
    m_active = 0; m_dead = 0; m_dead_left = 0;
    m_phase = 0; m_duty = 0; m_dir = 0;
    e_pwm = 0; e_tick = 0;
  endtask

  // Advance one clock; inputs are those present at the edge.
  task automatic step();
    logic [15:0] u_s;
    logic        en_s;
    int          tgt;
    u_s  = bus.u_in;
    en_s = bus.en;
    @(posedge clk);
    #1;
    if (!en_s) begin
      m_active = 0; m_dead = 0; m_dead_left = 0; m_phase = 0; m_duty = 0;
    end else if (!m_active) begin
      m_active = 1; m_phase = 0; m_duty = 0;
    end else if (m_phase != PERIOD - 1) begin
      m_phase++;
    end else begin
      m_phase = 0;
      tgt = target(u_s);
      if (m_dead) begin
        if (m_dead_left > 0) m_dead_left--;
        else begin
          m_dead = 0;
          if (u_s != 0) m_dir = u_s[15];
          m_duty = ramp(m_duty, tgt);
        end
      end else if (u_s != 0 && u_s[15] != m_dir) begin
        m_dead = 1; m_dead_left = DEAD_PERIODS - 1; m_duty = 0;
      end else begin
        m_duty = ramp(m_duty, tgt);
      end
    end
    e_pwm  = m_active && !m_dead && (m_phase < m_duty);
    e_tick = m_active && (m_phase == PERIOD - 1);
  endtask

  task automatic test_reset();
    bus.en = 1'b0; bus.u_in = 16'd0;
    #2 reset = 1'b1;
    #1;
    model_reset();
    n_tests++; if (bus.pwm !== 1'b0) begin n_fail++; $display("FAIL reset_pwm: got %b want 0", bus.pwm); end
    n_tests++; if (bus.dir !== 1'b0) begin n_fail++; $display("FAIL reset_dir: got %b want 0", bus.dir); end
    n_tests++; if (bus.duty !== '0) begin n_fail++; $display("FAIL reset_duty: got %0d want 0", bus.duty); end
    n_tests++; if (bus.period_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b want 0", bus.period_tick); end
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic test_forward();
    int highs = 0;
    int ticks = 0;
    bus.u_in = 16'd16000;
    bus.en   = 1'b1;
    for (int i = 1; i <= 2300; i++) begin
      step();
      n_tests++;
      if ({bus.pwm, bus.dir, bus.period_tick, bus.duty} !== {e_pwm, m_dir, e_tick, CNT_W'(m_duty)}) begin
        n_fail++;
        $display("FAIL fwd_cycle %0d: got pwm=%b dir=%b tick=%b duty=%0d want pwm=%b dir=%b tick=%b duty=%0d",
                 i, bus.pwm, bus.dir, bus.period_tick, bus.duty, e_pwm, m_dir, e_tick, m_duty);
      end
      if (i > 1000 && i <= 2000 && bus.pwm) highs++;
      if (bus.period_tick) ticks++;
    end
    n_tests++; if (highs != ramp(0, 500)) begin n_fail++; $display("FAIL fwd_high_count: got %0d want %0d", highs, ramp(0, 500)); end
    n_tests++; if (ticks != 2) begin n_fail++; $display("FAIL fwd_tick_count: got %0d want 2", ticks); end
  endtask

  task automatic test_reversal();
    int highs = 0;
    bus.u_in = 16'h8000;
    for (int i = 1; i <= 3500; i++) begin
      step();
      n_tests++;
      if ({bus.pwm, bus.dir, bus.period_tick, bus.duty} !== {e_pwm, m_dir, e_tick, CNT_W'(m_duty)}) begin
        n_fail++;
        $display("FAIL rev_cycle %0d: got pwm=%b dir=%b tick=%b duty=%0d want pwm=%b dir=%b tick=%b duty=%0d",
                 i, bus.pwm, bus.dir, bus.period_tick, bus.duty, e_pwm, m_dir, e_tick, m_duty);
      end
      if (i > 2500 && bus.pwm) highs++;
    end
`ifndef PWM_SOFTSTART_EN
    n_tests++; if (bus.dir !== 1'b1) begin n_fail++; $display("FAIL rev_dir: got %b want 1", bus.dir); end
    n_tests++; if (bus.duty !== 10'd1000) begin n_fail++; $display("FAIL rev_duty: got %0d want 1000", bus.duty); end
    n_tests++; if (highs != 1000) begin n_fail++; $display("FAIL rev_high_count: got %0d want 1000", highs); end
`endif
  endtask

  task automatic test_zero_reverse();
    int highs = 0;
    bus.u_in = 16'd0;
    for (int i = 1; i <= 2500; i++) begin
      step();
      n_tests++;
      if ({bus.pwm, bus.dir, bus.period_tick, bus.duty} !== {e_pwm, m_dir, e_tick, CNT_W'(m_duty)}) begin
        n_fail++;
        $display("FAIL zero_cycle %0d: got pwm=%b dir=%b tick=%b duty=%0d want pwm=%b dir=%b tick=%b duty=%0d",
                 i, bus.pwm, bus.dir, bus.period_tick, bus.duty, e_pwm, m_dir, e_tick, m_duty);
      end
      if (i > 1500 && bus.pwm) highs++;
    end
    n_tests++; if (bus.dir !== 1'b1) begin n_fail++; $display("FAIL zero_dir: got %b want 1", bus.dir); end
    n_tests++; if (bus.duty !== '0) begin n_fail++; $display("FAIL zero_duty: got %0d want 0", bus.duty); end
    n_tests++; if (highs != 0) begin n_fail++; $display("FAIL zero_high_count: got %0d want 0", highs); end
  endtask

  task automatic test_midperiod_change();
    int highs2 = 0;
    int highs3 = 0;
    reset = 1'b1; #1 model_reset();
    @(posedge clk); #1 reset = 1'b0;
    bus.u_in = 16'd16000;
    bus.en   = 1'b1;
    for (int i = 1; i <= 3100; i++) begin
      step();
      n_tests++;
      if ({bus.pwm, bus.dir, bus.period_tick, bus.duty} !== {e_pwm, m_dir, e_tick, CNT_W'(m_duty)}) begin
        n_fail++;
        $display("FAIL mid_cycle %0d: got pwm=%b dir=%b tick=%b duty=%0d want pwm=%b dir=%b tick=%b duty=%0d",
                 i, bus.pwm, bus.dir, bus.period_tick, bus.duty, e_pwm, m_dir, e_tick, m_duty);
      end
      if (i > 1000 && i <= 2000 && bus.pwm) highs2++;
      if (i > 2000 && i <= 3000 && bus.pwm) highs3++;
      if (i == 1201) bus.u_in = 16'd3200;   // counter now at 200
    end
    n_tests++; if (highs2 != ramp(0, 500)) begin n_fail++; $display("FAIL mid_cur_period: got %0d want %0d", highs2, ramp(0, 500)); end
    n_tests++; if (highs3 != ramp(ramp(0, 500), 100)) begin n_fail++; $display("FAIL mid_next_period: got %0d want %0d", highs3, ramp(ramp(0, 500), 100)); end
  endtask

  task automatic test_reset_midperiod();
    int  highs = 0;
    bit  found = 0;
    bus.u_in = 16'd16000;
    for (int i = 0; i < 8000 && !found; i++) begin
      step();
      n_tests++;
      if ({bus.pwm, bus.dir, bus.period_tick, bus.duty} !== {e_pwm, m_dir, e_tick, CNT_W'(m_duty)}) begin
        n_fail++;
        $display("FAIL rstmid_cycle %0d: got pwm=%b dir=%b tick=%b duty=%0d want pwm=%b dir=%b tick=%b duty=%0d",
                 i, bus.pwm, bus.dir, bus.period_tick, bus.duty, e_pwm, m_dir, e_tick, m_duty);
      end
      if (m_phase == 300 && e_pwm) found = 1;
    end
    n_tests++; if (!found) begin n_fail++; $display("FAIL rstmid_wait: got timeout want cnt=300 with pwm high"); end
    reset = 1'b1;
    #1;
    model_reset();
    n_tests++;
    if ({bus.pwm, bus.dir, bus.period_tick, bus.duty} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_async: got pwm=%b dir=%b tick=%b duty=%0d want all 0",
               bus.pwm, bus.dir, bus.period_tick, bus.duty);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 1; i <= 1100; i++) begin
      step();
      n_tests++;
      if ({bus.pwm, bus.dir, bus.period_tick, bus.duty} !== {e_pwm, m_dir, e_tick, CNT_W'(m_duty)}) begin
        n_fail++;
        $display("FAIL rstmid_after %0d: got pwm=%b dir=%b tick=%b duty=%0d want pwm=%b dir=%b tick=%b duty=%0d",
                 i, bus.pwm, bus.dir, bus.period_tick, bus.duty, e_pwm, m_dir, e_tick, m_duty);
      end
      if (i <= 1000 && bus.pwm) highs++;
    end
    n_tests++; if (highs != 0) begin n_fail++; $display("FAIL rstmid_first_period: got %0d highs want 0", highs); end
  endtask

`ifdef PWM_SOFTSTART_EN
  task automatic test_softstart();
    reset = 1'b1; #1 model_reset();
    @(posedge clk); #1 reset = 1'b0;
    bus.u_in = 16'd16000;
    bus.en   = 1'b1;
    for (int i = 1; i <= 11000; i++) begin
      step();
      n_tests++;
      if ({bus.pwm, bus.dir, bus.period_tick, bus.duty} !== {e_pwm, m_dir, e_tick, CNT_W'(m_duty)}) begin
        n_fail++;
        $display("FAIL soft_cycle %0d: got pwm=%b duty=%0d want pwm=%b duty=%0d", i, bus.pwm, bus.duty, e_pwm, m_duty);
      end
      if (i > 1000 && (i % 1000) == 1) begin
        n_tests++;
        if (int'(bus.duty) != 50 * (i / 1000)) begin
          n_fail++;
          $display("FAIL soft_ramp %0d: got duty=%0d want %0d", i / 1000, bus.duty, 50 * (i / 1000));
        end
      end
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 1; i <= 20000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        case ($urandom_range(0, 4))
          0: bus.u_in = 16'($urandom);
          1: bus.u_in = 16'd0;
          2: bus.u_in = 16'h8000;
          3: bus.u_in = 16'($urandom_range(0, 2000));
          default: bus.u_in = -16'($urandom_range(1, 2000));
        endcase
      end
      if (bus.en && $urandom_range(0, 4999) == 0) bus.en = 1'b0;
      else if (!bus.en && $urandom_range(0, 3) == 0) bus.en = 1'b1;
      step();
      n_tests++;
      if ({bus.pwm, bus.dir, bus.period_tick, bus.duty} !== {e_pwm, m_dir, e_tick, CNT_W'(m_duty)}) begin
        n_fail++;
        $display("FAIL rand_cycle %0d: u=%0d en=%b got pwm=%b dir=%b tick=%b duty=%0d want pwm=%b dir=%b tick=%b duty=%0d",
                 i, $signed(bus.u_in), bus.en, bus.pwm, bus.dir, bus.period_tick, bus.duty, e_pwm, m_dir, e_tick, m_duty);
      end
    end
  endtask

  initial begin
    bus.en   = 1'b0;
    bus.u_in = 16'd0;
    test_reset();
    test_forward();
    test_reversal();
    test_zero_reverse();
    test_midperiod_change();
    test_reset_midperiod();
`ifdef PWM_SOFTSTART_EN
    test_softstart();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pid_pwm_driver.md
Name: pid_pwm_driver

Overview:
Downstream stage of the PID controller. Consumes the 16-bit signed controller output (u_out of PID) and turns it into a motor-driver PWM signal plus a direction line.
- Duty is latched once per PWM period, never mid-period.
- A reversal in direction forces a dead-time gap before the new direction is driven.

Parameters:
PERIOD, 1000, PWM period in clk cycles; counter runs 0..PERIOD-1.
CNT_W, 10, counter and duty width; requires 2^CNT_W >= PERIOD.
U_SHIFT, 5, right-shift applied to |u_in| to scale it into duty counts.
DEAD_PERIODS, 1, number of full periods with pwm forced low on a direction reversal (>=1).
SLEW_STEP, 50, maximum duty change per period; used only with PWM_SOFTSTART_EN.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
u_in  in  16  signed two's-complement control effort from PID u_out
en  in  1  synchronous enable; 0 forces idle
pwm  out  1  registered PWM output to the motor driver
dir  out  1  registered direction: 0 = forward (u>=0), 1 = reverse (u<0)
duty  out  CNT_W  duty currently being applied
period_tick  out  1  one-cycle pulse on the last cycle of each period (cnt==PERIOD-1)

Behaviour:
- Reset (async, active-high) sets all outputs and state as follows:
  - cnt=0, state=IDLE
  - pwm=0, dir=0, duty=0, period_tick=0
  - dead-period counter=0
- States:
  - IDLE: counter held at 0, pwm=0, duty=0, dir held.
  - RUN: counter free-running.
  - DEAD: counter free-running, pwm=0, duty=0.
- State transitions:
  - IDLE -> RUN when en=1. The counter starts at 0 on the next cycle. The first period runs with duty 0; the first sample is loaded at its tick.
  - Any state -> IDLE when en=0, synchronously. cnt and duty are cleared on the same edge.
- Counter: cnt increments each cycle and wraps PERIOD-1 -> 0. period_tick=1 exactly when cnt==PERIOD-1.
- Sampling happens only on a period_tick cycle. The new duty/dir take effect from cnt=0 of the next period.
- Magnitude computation:
  - mag = |u_in| as 17-bit unsigned, so -32768 gives 32768.
  - scaled = mag >> U_SHIFT.
  - duty_new = min(scaled, PERIOD), i.e. saturating.
- Sign handling:
  - sign_new = u_in[15].
  - u_in==0 gives duty_new=0, and dir keeps its previous value (no reversal triggered).
- Transitions at tick in RUN:
  - If u_in != 0 and sign_new != dir, go to DEAD. Load dead_cnt = DEAD_PERIODS-1 and set duty=0. dir is unchanged.
  - Otherwise stay in RUN, with duty <= duty_new.
- Transitions at tick in DEAD:
  - If dead_cnt != 0, decrement it.
  - If dead_cnt == 0, load a fresh sample: dir <= sign_new (or held if u_in==0), duty <= duty_new, go to RUN.
  - A sign flip back while in DEAD does not extend the gap. The fresh sample decides the direction.
- PWM output: pwm is registered. pwm <= (state==RUN) && (cnt_next < duty).
  - duty=0 gives pwm constantly low.
  - duty=PERIOD gives pwm constantly high with no glitch at wrap.
- Latency: an applied duty of D gives exactly D high cycles per period, starting at cnt=0 (pwm rises on the edge where cnt becomes 0).
- u_in changes mid-period are ignored until the next tick.
- Reset mid-period: immediate return to reset values. The next enable starts a clean period.

Optional Feature:
Macro PWM_SOFTSTART_EN.
- Defined: at each RUN-state load, duty moves toward duty_new by at most SLEW_STEP (duty += / -= min(|diff|, SLEW_STEP)). A load exiting DEAD starts ramping from 0.
- Undefined: duty jumps directly to duty_new; SLEW_STEP is unused.

Decomposition:
- Package pid_pkg holds:
  - U_W=16
  - default PWM_PERIOD
  - state encoding (IDLE, RUN, DEAD)
  - a saturating |u|>>shift helper function shared with the PID block.
- One natural sub-module, pwm_period_counter: counter, wrap logic and period_tick generation.
- Duty/dir FSM and compare logic stay in the top module.

Test Plan (all with defaults PERIOD=1000, U_SHIFT=5, DEAD_PERIODS=1):
- en=1, u_in=16000 held -> duty=500 from the second period; pwm high exactly 500 cycles, low 500 cycles; dir=0; period_tick every 1000 cycles.
- u_in=-32768 after steady forward -> one full period with pwm=0 (DEAD), then dir=1, duty=1000, pwm constantly high across wraps.
- u_in=0 while reverse -> duty=0, pwm low, dir stays 1, no DEAD entry.
- u_in changes 16000->3200 at cnt=200 -> current period still 500 high; next period 100 high.
- reset asserted at cnt=300 mid-high -> pwm, dir, duty, period_tick go to 0 immediately; after release with en=1, first period all low.
- PWM_SOFTSTART_EN defined, u_in 0->16000 -> duty sequence 50, 100, ... 500 over 10 periods.
